// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared core constants for the pipeline controller and its consumers
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // addi x0, x0, 0: loaded by IF/ID and ID/EX when flushed
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - redirect arbitration, stall combining and flush sequencing for the 5-stage core
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_jump_en_i,
    input  logic [WIDTH-1:0] ex_jump_addr_i,
    input  logic             irq_jump_en_i,
    input  logic [WIDTH-1:0] irq_jump_addr_i,
    input  logic             hold_div_i,
    input  logic             hold_bus_i,
    output logic             jump_en_o,
    output logic [WIDTH-1:0] jump_addr_o,
    output logic             hold_pc_o,
    output logic             hold_if_id_o,
    output logic             hold_id_ex_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             pend_o
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    // With a single flush cycle the issue cycle itself covers it, so go straight back to RUN
    localparam state_t ST_AFTER_ISSUE = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pend_addr, pend_addr_nxt;
    logic             pend_irq, pend_irq_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             hold;
    logic             issue;
    logic [WIDTH-1:0] issue_addr;

    assign hold = hold_div_i | hold_bus_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            pend_addr <= '0;
            pend_irq  <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            pend_addr <= pend_addr_nxt;
            pend_irq  <= pend_irq_nxt;
            cnt       <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pend_addr_nxt = pend_addr;
        pend_irq_nxt  = pend_irq;
        cnt_nxt       = cnt;
        issue         = 1'b0;
        issue_addr    = '0;

        case (state)
            ST_RUN: begin
                if (irq_jump_en_i || ex_jump_en_i) begin
                    if (!hold) begin
                        issue      = 1'b1;
                        issue_addr = irq_jump_en_i ? irq_jump_addr_i : ex_jump_addr_i;
                    end else begin
                        state_nxt     = ST_PEND;
                        pend_addr_nxt = irq_jump_en_i ? irq_jump_addr_i : ex_jump_addr_i;
                        pend_irq_nxt  = irq_jump_en_i;
                    end
                end
            end

            ST_PEND: begin
                if (hold) begin
                    // A trap outranks a buffered branch; ex requests behind the stall are stale
                    if (irq_jump_en_i && !pend_irq) begin
                        pend_addr_nxt = irq_jump_addr_i;
                        pend_irq_nxt  = 1'b1;
                    end
                end else begin
                    issue      = 1'b1;
                    issue_addr = (irq_jump_en_i && !pend_irq) ? irq_jump_addr_i : pend_addr;
                end
            end

            ST_FLUSH: begin
                // ex requests here come from squashed instructions and are dropped
                if (irq_jump_en_i) begin
                    if (!hold) begin
                        issue      = 1'b1;
                        issue_addr = irq_jump_addr_i;
                    end else begin
                        state_nxt     = ST_PEND;
                        pend_addr_nxt = irq_jump_addr_i;
                        pend_irq_nxt  = 1'b1;
                        cnt_nxt       = '0;
                    end
                end else if (!hold) begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end
                end
            end

            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase

        if (issue) begin
            state_nxt     = ST_AFTER_ISSUE;
            cnt_nxt       = CNT_RELOAD;
            pend_addr_nxt = '0;
            pend_irq_nxt  = 1'b0;
        end
    end

    always_comb begin
        hold_pc_o     = hold;
        hold_if_id_o  = hold;
        hold_id_ex_o  = hold;
        jump_en_o     = 1'b0;
        jump_addr_o   = '0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        pend_o        = 1'b0;
        if (!rst) begin
            jump_en_o     = issue;
            jump_addr_o   = issue ? issue_addr : '0;
            flush_if_id_o = issue || (state == ST_FLUSH);
            flush_id_ex_o = issue;
            pend_o        = (state == ST_PEND) && !issue;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and random stimulus against a redirect/flush reference model
module tb_pipe_ctrl;

    localparam int W  = 32;
    localparam int FC = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         ex_jump_en;
    logic [W-1:0] ex_jump_addr;
    logic         irq_jump_en;
    logic [W-1:0] irq_jump_addr;
    logic         hold_div;
    logic         hold_bus;
    logic         jump_en;
    logic [W-1:0] jump_addr;
    logic         hold_pc;
    logic         hold_if_id;
    logic         hold_id_ex;
    logic         flush_if_id;
    logic         flush_id_ex;
    logic         pend;

    int errors = 0;
    int checks = 0;

    // Model state: a buffered redirect and the number of flush-only cycles still owed
    bit           m_pending;
    bit           m_pirq;
    logic [W-1:0] m_ptgt;
    int           m_flush_left;

    always #5 clk = ~clk;

    pipe_ctrl #(.WIDTH(W), .FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_jump_en_i   (ex_jump_en),
        .ex_jump_addr_i (ex_jump_addr),
        .irq_jump_en_i  (irq_jump_en),
        .irq_jump_addr_i(irq_jump_addr),
        .hold_div_i     (hold_div),
        .hold_bus_i     (hold_bus),
        .jump_en_o      (jump_en),
        .jump_addr_o    (jump_addr),
        .hold_pc_o      (hold_pc),
        .hold_if_id_o   (hold_if_id),
        .hold_id_ex_o   (hold_id_ex),
        .flush_if_id_o  (flush_if_id),
        .flush_id_ex_o  (flush_id_ex),
        .pend_o         (pend)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input bit r, input bit e, input logic [W-1:0] ea,
                       input bit i, input logic [W-1:0] ia, input bit d, input bit b);
        bit           h;
        bit           iss;
        bit           x_pend;
        bit           x_fif;
        logic [W-1:0] tgt;
        @(negedge clk);
        rst = r; ex_jump_en = e; ex_jump_addr = ea;
        irq_jump_en = i; irq_jump_addr = ia; hold_div = d; hold_bus = b;
        #1;
        h = d | b; iss = 1'b0; x_pend = 1'b0; x_fif = 1'b0; tgt = '0;
        if (r) begin
            m_pending = 1'b0; m_pirq = 1'b0; m_ptgt = '0; m_flush_left = 0;
        end else if (m_pending) begin
            if (!h) begin
                iss = 1'b1;
                tgt = (i && !m_pirq) ? ia : m_ptgt;
            end else begin
                x_pend = 1'b1;
                if (i && !m_pirq) begin m_ptgt = ia; m_pirq = 1'b1; end
            end
        end else if (m_flush_left > 0) begin
            x_fif = 1'b1;
            if (i && !h) begin
                iss = 1'b1; tgt = ia;
            end else if (i) begin
                m_pending = 1'b1; m_pirq = 1'b1; m_ptgt = ia; m_flush_left = 0;
            end else if (!h) begin
                m_flush_left--;
            end
        end else if (i || e) begin
            if (!h) begin
                iss = 1'b1; tgt = i ? ia : ea;
            end else begin
                m_pending = 1'b1; m_pirq = i; m_ptgt = i ? ia : ea;
            end
        end
        if (iss) begin
            x_fif = 1'b1;
            m_pending = 1'b0; m_pirq = 1'b0; m_ptgt = '0; m_flush_left = FC - 1;
        end
        check("jump_en",     W'(jump_en),     W'(iss));
        check("jump_addr",   jump_addr,       iss ? tgt : '0);
        check("hold_pc",     W'(hold_pc),     W'(h));
        check("hold_if_id",  W'(hold_if_id),  W'(h));
        check("hold_id_ex",  W'(hold_id_ex),  W'(h));
        check("flush_if_id", W'(flush_if_id), W'(x_fif));
        check("flush_id_ex", W'(flush_id_ex), W'(iss));
        check("pend",        W'(pend),        W'(x_pend));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, '0, 0, '0, 0, 0);
    endtask

    initial begin
        m_pending = 1'b0; m_pirq = 1'b0; m_ptgt = '0; m_flush_left = 0;

        cyc(1, 0, '0, 0, '0, 0, 0);
        cyc(1, 1, 32'h44, 1, 32'h88, 1, 0);
        idle(2);

        // plain ex redirect with no stall
        cyc(0, 1, 32'h100, 0, '0, 0, 0);
        idle(4);

        // irq beats ex in the same cycle
        cyc(0, 1, 32'h200, 1, 32'h80, 0, 0);
        idle(4);

        // ex buffered behind a 3-cycle bus stall
        cyc(0, 1, 32'h40, 0, '0, 0, 1);
        cyc(0, 0, '0, 0, '0, 0, 1);
        cyc(0, 0, '0, 0, '0, 0, 1);
        cyc(0, 0, '0, 0, '0, 0, 0);
        idle(4);

        // buffered ex replaced by irq while still stalled
        cyc(0, 1, 32'h40, 0, '0, 0, 1);
        cyc(0, 1, 32'h44, 0, '0, 0, 1);
        cyc(0, 0, '0, 1, 32'h80, 0, 1);
        cyc(0, 0, '0, 1, 32'h90, 0, 1);
        cyc(0, 0, '0, 0, '0, 0, 0);
        idle(4);

        // release of a buffered ex coincides with a fresh irq
        cyc(0, 1, 32'h50, 0, '0, 1, 0);
        cyc(0, 0, '0, 1, 32'hA0, 0, 0);
        idle(4);

        // divider stall freezes the flush counter
        cyc(0, 1, 32'h300, 0, '0, 0, 0);
        cyc(0, 0, '0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, '0, 1, 0);
        idle(4);

        // irq inside the flush window: issued directly, then under hold
        cyc(0, 1, 32'h10, 0, '0, 0, 0);
        cyc(0, 1, 32'h14, 1, 32'h20, 0, 0);
        cyc(0, 0, '0, 1, 32'h30, 0, 1);
        cyc(0, 0, '0, 0, '0, 0, 1);
        cyc(0, 0, '0, 0, '0, 0, 0);
        idle(4);

        // reset while pending discards the buffered redirect
        cyc(0, 1, 32'h40, 0, '0, 0, 1);
        cyc(0, 0, '0, 0, '0, 0, 1);
        cyc(1, 0, '0, 0, '0, 0, 1);
        cyc(0, 0, '0, 0, '0, 0, 1);
        cyc(0, 0, '0, 0, '0, 0, 0);
        idle(3);

        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(99) < 2,
                $urandom_range(99) < 30, $urandom,
                $urandom_range(99) < 15, $urandom,
                $urandom_range(99) < 20,
                $urandom_range(99) < 20);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
